// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register, plus the madd/msub accumulator and step counter fed back to EX.
// Optional macro EX_MEM_PERF_EN adds a saturating 32-bit bubble_cnt output (bubble + flush edges).
module ex_mem_reg #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CNTW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall_ex,
   input  logic              stall_mem,
   input  logic              ex_valid,
   input  logic [AW-1:0]     ex_wd,
   input  logic              ex_wreg,
   input  logic [DW-1:0]     ex_wdata,
   input  logic              ex_whilo,
   input  logic [DW-1:0]     ex_hi,
   input  logic [DW-1:0]     ex_lo,
   input  logic [2*DW-1:0]   ex_hilo_temp,
   input  logic [CNTW-1:0]   ex_cnt,
   output logic              mem_valid,
   output logic [AW-1:0]     mem_wd,
   output logic              mem_wreg,
   output logic [DW-1:0]     mem_wdata,
   output logic              mem_whilo,
   output logic [DW-1:0]     mem_hi,
   output logic [DW-1:0]     mem_lo,
   output logic [2*DW-1:0]   hilo_temp_o,
   output logic [CNTW-1:0]   cnt_o
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0]       bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      PATH_LOAD,
      PATH_BUBBLE,
      PATH_HOLD,
      PATH_FLUSH
   } path_t;

   path_t path;

   logic              valid_reg,     valid_next;
   logic [AW-1:0]     wd_reg,        wd_next;
   logic              wreg_reg,      wreg_next;
   logic [DW-1:0]     wdata_reg,     wdata_next;
   logic              whilo_reg,     whilo_next;
   logic [DW-1:0]     hi_reg,        hi_next;
   logic [DW-1:0]     lo_reg,        lo_next;
   logic [2*DW-1:0]   hilo_temp_reg, hilo_temp_next;
   logic [CNTW-1:0]   cnt_reg,       cnt_next;

   // The illegal stall_ex=0/stall_mem=1 combination falls through to hold.
   always_comb begin
      path = PATH_HOLD;
      if (flush)
         path = PATH_FLUSH;
      else if (!stall_ex && !stall_mem)
         path = PATH_LOAD;
      else if (stall_ex && !stall_mem)
         path = PATH_BUBBLE;
   end

   always_comb begin
      valid_next     = valid_reg;
      wd_next        = wd_reg;
      wreg_next      = wreg_reg;
      wdata_next     = wdata_reg;
      whilo_next     = whilo_reg;
      hi_next        = hi_reg;
      lo_next        = lo_reg;
      hilo_temp_next = hilo_temp_reg;
      cnt_next       = cnt_reg;
      case (path)
         PATH_LOAD: begin
            valid_next     = ex_valid;
            wd_next        = ex_wd;
            wreg_next      = ex_wreg & ex_valid;
            wdata_next     = ex_wdata;
            whilo_next     = ex_whilo & ex_valid;
            hi_next        = ex_hi;
            lo_next        = ex_lo;
            hilo_temp_next = '0;
            cnt_next       = '0;
         end
         PATH_BUBBLE: begin
            // NOP into MEM while EX keeps its partial result for the next step.
            valid_next     = 1'b0;
            wd_next        = '0;
            wreg_next      = 1'b0;
            wdata_next     = '0;
            whilo_next     = 1'b0;
            hi_next        = '0;
            lo_next        = '0;
            hilo_temp_next = ex_hilo_temp;
            cnt_next       = ex_cnt;
         end
         PATH_FLUSH: begin
            valid_next     = 1'b0;
            wd_next        = '0;
            wreg_next      = 1'b0;
            wdata_next     = '0;
            whilo_next     = 1'b0;
            hi_next        = '0;
            lo_next        = '0;
            hilo_temp_next = '0;
            cnt_next       = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg     <= 1'b0;
         wd_reg        <= '0;
         wreg_reg      <= 1'b0;
         wdata_reg     <= '0;
         whilo_reg     <= 1'b0;
         hi_reg        <= '0;
         lo_reg        <= '0;
         hilo_temp_reg <= '0;
         cnt_reg       <= '0;
      end else begin
         valid_reg     <= valid_next;
         wd_reg        <= wd_next;
         wreg_reg      <= wreg_next;
         wdata_reg     <= wdata_next;
         whilo_reg     <= whilo_next;
         hi_reg        <= hi_next;
         lo_reg        <= lo_next;
         hilo_temp_reg <= hilo_temp_next;
         cnt_reg       <= cnt_next;
      end
   end

   assign mem_valid   = valid_reg;
   assign mem_wd      = wd_reg;
   assign mem_wreg    = wreg_reg;
   assign mem_wdata   = wdata_reg;
   assign mem_whilo   = whilo_reg;
   assign mem_hi      = hi_reg;
   assign mem_lo      = lo_reg;
   assign hilo_temp_o = hilo_temp_reg;
   assign cnt_o       = cnt_reg;

`ifdef EX_MEM_PERF_EN
   logic [31:0] bubble_cnt_reg;
   logic        bubble_evt;

   assign bubble_evt = (path == PATH_BUBBLE) || (path == PATH_FLUSH);

   // Saturating: stays at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         bubble_cnt_reg <= '0;
      else if (bubble_evt && (bubble_cnt_reg != 32'hFFFF_FFFF))
         bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
   end

   assign bubble_cnt = bubble_cnt_reg;
`endif

   // The stall controller must never stall MEM while letting EX advance.
   assert property (@(posedge clk) disable iff (rst || flush) !(stall_mem && !stall_ex));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed steps then random traffic against a behavioural model.
module tb_ex_mem_reg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CNTW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, flush, stall_ex, stall_mem;
   logic            ex_valid, ex_wreg, ex_whilo;
   logic [AW-1:0]   ex_wd;
   logic [DW-1:0]   ex_wdata, ex_hi, ex_lo;
   logic [2*DW-1:0] ex_hilo_temp;
   logic [CNTW-1:0] ex_cnt;

   logic            mem_valid, mem_wreg, mem_whilo;
   logic [AW-1:0]   mem_wd;
   logic [DW-1:0]   mem_wdata, mem_hi, mem_lo;
   logic [2*DW-1:0] hilo_temp_o;
   logic [CNTW-1:0] cnt_o;
`ifdef EX_MEM_PERF_EN
   logic [31:0]     bubble_cnt;
`endif

   ex_mem_reg #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .stall_ex     (stall_ex),
      .stall_mem    (stall_mem),
      .ex_valid     (ex_valid),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_wdata     (ex_wdata),
      .ex_whilo     (ex_whilo),
      .ex_hi        (ex_hi),
      .ex_lo        (ex_lo),
      .ex_hilo_temp (ex_hilo_temp),
      .ex_cnt       (ex_cnt),
      .mem_valid    (mem_valid),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .mem_whilo    (mem_whilo),
      .mem_hi       (mem_hi),
      .mem_lo       (mem_lo),
      .hilo_temp_o  (hilo_temp_o),
      .cnt_o        (cnt_o)
`ifdef EX_MEM_PERF_EN
      ,
      .bubble_cnt   (bubble_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_step   = 0;

   // Model of what MEM (and the EX feedback) should hold after each edge.
   logic            m_valid, m_wreg, m_whilo;
   logic [AW-1:0]   m_wd;
   logic [DW-1:0]   m_wdata, m_hi, m_lo;
   logic [2*DW-1:0] m_temp;
   logic [CNTW-1:0] m_cnt;
   longint unsigned m_bubbles;

   task automatic model_clear();
      m_valid = 0; m_wreg = 0; m_whilo = 0; m_wd = '0;
      m_wdata = '0; m_hi = '0; m_lo = '0; m_temp = '0; m_cnt = '0;
   endtask

   task automatic model_edge(output string kind);
      if (rst) begin
         model_clear();
         m_bubbles = 0;
         kind = "reset";
      end else if (flush) begin
         model_clear();
         m_bubbles++;
         kind = "flush";
      end else if (!stall_ex) begin
         m_valid = ex_valid; m_wd = ex_wd; m_wdata = ex_wdata;
         m_wreg = ex_valid && ex_wreg; m_whilo = ex_valid && ex_whilo;
         m_hi = ex_hi; m_lo = ex_lo; m_temp = '0; m_cnt = '0;
         kind = "load";
      end else if (!stall_mem) begin
         model_clear();
         m_temp = ex_hilo_temp; m_cnt = ex_cnt;
         m_bubbles++;
         kind = "bubble";
      end else begin
         kind = "hold";
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("mem_valid",   64'(mem_valid),   64'(m_valid));
      check("mem_wd",      64'(mem_wd),      64'(m_wd));
      check("mem_wreg",    64'(mem_wreg),    64'(m_wreg));
      check("mem_wdata",   64'(mem_wdata),   64'(m_wdata));
      check("mem_whilo",   64'(mem_whilo),   64'(m_whilo));
      check("mem_hi",      64'(mem_hi),      64'(m_hi));
      check("mem_lo",      64'(mem_lo),      64'(m_lo));
      check("hilo_temp_o", hilo_temp_o,      m_temp);
      check("cnt_o",       64'(cnt_o),       64'(m_cnt));
`ifdef EX_MEM_PERF_EN
      check("bubble_cnt",  64'(bubble_cnt),  (m_bubbles > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bubbles);
`endif
   endtask

   task automatic step();
      string kind;
      @(posedge clk);
      model_edge(kind);
      #1;
      n_step++;
      $display("step %0d %-6s valid=%0b wd=%0d wreg=%0b wdata=%h whilo=%0b lo=%h temp=%h cnt=%0d",
               n_step, kind, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_lo,
               hilo_temp_o, cnt_o);
      check_all();
   endtask

   task automatic set_ex(input logic v, input logic [AW-1:0] wd, input logic wr,
                         input logic [DW-1:0] wdata, input logic whl,
                         input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                         input logic [2*DW-1:0] temp, input logic [CNTW-1:0] cnt);
      ex_valid = v; ex_wd = wd; ex_wreg = wr; ex_wdata = wdata; ex_whilo = whl;
      ex_hi = hi; ex_lo = lo; ex_hilo_temp = temp; ex_cnt = cnt;
   endtask

   task automatic rand_ex();
      set_ex(1'($urandom), AW'($urandom), 1'($urandom), $urandom, 1'($urandom),
             $urandom, $urandom, {$urandom, $urandom}, CNTW'($urandom));
   endtask

   initial begin
      model_clear();
      m_bubbles = 0;
      flush = 0; stall_ex = 0; stall_mem = 0;

      // Reset with every EX input at all ones.
      rst = 1;
      set_ex(1'b1, '1, 1'b1, '1, 1'b1, '1, '1, '1, '1);
      step();
      step();
      check("rst_wdata_zero", 64'(mem_wdata), 64'd0);
      check("rst_temp_zero",  hilo_temp_o,    64'd0);

      // First edge after release loads.
      rst = 0;
      step();
      check("post_rst_wdata", 64'(mem_wdata), 64'hFFFF_FFFF);
      check("post_rst_cnt",   64'(cnt_o),     64'd0);

      // Normal load.
      set_ex(1'b1, 5'd3, 1'b1, 32'h0000_F0F0, 1'b0, '0, '0, '0, '0);
      step();
      check("load_wd",    64'(mem_wd),    64'd3);
      check("load_wdata", 64'(mem_wdata), 64'h0000_F0F0);
      check("load_valid", 64'(mem_valid), 64'd1);

      // madd: step 1 bubbles with a partial accumulator, step 2 loads the HI/LO write.
      stall_ex = 1; stall_mem = 0;
      set_ex(1'b1, 5'd0, 1'b0, '0, 1'b0, '0, '0, 64'h0000_0001_0000_0002, 2'd1);
      step();
      check("madd1_temp",  hilo_temp_o,    64'h0000_0001_0000_0002);
      check("madd1_cnt",   64'(cnt_o),     64'd1);
      check("madd1_valid", 64'(mem_valid), 64'd0);
      stall_ex = 0;
      set_ex(1'b1, 5'd0, 1'b0, '0, 1'b1, 32'h1, 32'h5, '0, '0);
      step();
      check("madd2_whilo", 64'(mem_whilo), 64'd1);
      check("madd2_lo",    64'(mem_lo),    64'd5);
      check("madd2_temp",  hilo_temp_o,    64'd0);

      // Hold after a load: wdata frozen while input toggles.
      set_ex(1'b1, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, '0, '0, '0);
      step();
      stall_ex = 1; stall_mem = 1;
      for (int i = 0; i < 3; i++) begin
         ex_wdata = ~ex_wdata;
         ex_hilo_temp = {$urandom, $urandom};
         ex_cnt = CNTW'(i + 1);
         step();
         check("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      end

      // Hold after a bubble: accumulator and counter frozen.
      stall_mem = 0;
      ex_hilo_temp = 64'h1234_5678_9ABC_DEF0; ex_cnt = 2'd3;
      step();
      stall_mem = 1;
      for (int i = 0; i < 3; i++) begin
         ex_hilo_temp = {$urandom, $urandom};
         ex_cnt = CNTW'(i);
         step();
         check("hold_temp", hilo_temp_o, 64'h1234_5678_9ABC_DEF0);
         check("hold_cnt",  64'(cnt_o),  64'd3);
      end

      // Flush wins over a full hold while valid data sits in MEM.
      stall_ex = 0; stall_mem = 0;
      set_ex(1'b1, 5'd7, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h11, 32'h22, '0, '0);
      step();
      flush = 1; stall_ex = 1; stall_mem = 1;
      step();
      check("flush_valid", 64'(mem_valid), 64'd0);
      check("flush_wdata", 64'(mem_wdata), 64'd0);
      flush = 0; stall_ex = 0; stall_mem = 0;

      // Write enables are dropped for an invalid slot.
      set_ex(1'b0, 5'd4, 1'b1, 32'h5555_AAAA, 1'b1, '1, '1, '0, '0);
      step();
      check("inv_wreg",  64'(mem_wreg),  64'd0);
      check("inv_whilo", 64'(mem_whilo), 64'd0);
      check("inv_valid", 64'(mem_valid), 64'd0);

      // Random traffic; only legal stall combinations are driven.
      for (int i = 0; i < 300; i++) begin
         int unsigned sel;
         rand_ex();
         sel = $urandom_range(0, 99);
         rst   = (sel < 3);
         flush = (sel >= 3 && sel < 12);
         case ($urandom_range(0, 2))
            0: begin stall_ex = 0; stall_mem = 0; end
            1: begin stall_ex = 1; stall_mem = 0; end
            default: begin stall_ex = 1; stall_mem = 1; end
         endcase
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Carries the EX result (destination reg, write enable, ALU result, HI/LO write) into MEM under stall/flush control.
- Also holds the intermediate 64-bit accumulator and step counter that two-cycle EX ops (madd/msub) feed back into EX while EX is stalled.

Parameters:
DW, 32, data/register width
AW, 5, register-file address width
CNTW, 2, multi-cycle step counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
flush  in  1  squash the EX/MEM contents (exception/branch-likely kill)
stall_ex  in  1  EX stage stalled this cycle
stall_mem  in  1  MEM stage stalled this cycle
ex_valid  in  1  EX output carries a real instruction
ex_wd  in  AW  destination register address
ex_wreg  in  1  register-file write enable
ex_wdata  in  DW  EX result
ex_whilo  in  1  HI/LO write enable
ex_hi  in  DW  HI write value
ex_lo  in  DW  LO write value
ex_hilo_temp  in  2*DW  partial accumulator from EX
ex_cnt  in  CNTW  EX multi-cycle step index
mem_valid  out  1  MEM slot holds a real instruction
mem_wd  out  AW  registered ex_wd
mem_wreg  out  1  registered ex_wreg
mem_wdata  out  DW  registered ex_wdata
mem_whilo  out  1  registered ex_whilo
mem_hi  out  DW  registered ex_hi
mem_lo  out  DW  registered ex_lo
hilo_temp_o  out  2*DW  accumulator fed back to EX
cnt_o  out  CNTW  step counter fed back to EX

Behaviour:
- Reset: rst=1 at a clock edge clears all outputs to 0: mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_temp_o, cnt_o.
- Priority per edge: rst > flush > stall decode > normal load.
- flush=1:
  - Clears all mem_* outputs, hilo_temp_o and cnt_o to 0 (bubble), regardless of the stall inputs.
  - A flush mid multi-cycle op discards the accumulator.
- Stall decode: exactly one of the following applies each edge.
  - Load (stall_ex=0): all mem_* outputs take their ex_* inputs; mem_valid<=ex_valid; hilo_temp_o<=0; cnt_o<=0. Latency is 1 cycle.
  - Bubble (stall_ex=1, stall_mem=0):
    - mem_valid, mem_wreg and mem_whilo go to 0; mem_wd, mem_wdata, mem_hi and mem_lo go to 0.
    - hilo_temp_o<=ex_hilo_temp; cnt_o<=ex_cnt.
    - Net effect: a NOP goes to MEM and the partial result is kept for EX's next step.
  - Hold (stall_ex=1, stall_mem=1): every register keeps its value, including hilo_temp_o and cnt_o.
  - stall_ex=0 with stall_mem=1 is illegal per the stall controller contract. The block treats it as Hold, and an assertion flags it in simulation.
- No combinational path exists from any input to any output. All outputs are registered.
- Write enables are qualified: mem_wreg and mem_whilo are forced to 0 whenever the loaded ex_valid=0.
- cnt_o is passed through unchanged; it is not incremented. EX owns the step sequencing. Values wrap modulo 2^CNTW as supplied.

Optional Feature:
- Macro EX_MEM_PERF_EN.
- When defined:
  - Adds output bubble_cnt (32 bits).
  - Cleared on rst.
  - Increments by 1 on every edge that takes the Bubble path or the flush path.
  - Saturates at 0xFFFFFFFF; it does not wrap.
  - Hold edges do not count.
- When undefined: the port and its counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all ex_* inputs = all ones -> every output reads 0; release rst -> the next edge loads values.
- Normal load: ex_valid=1, ex_wd=5'd3, ex_wreg=1, ex_wdata=0x0000F0F0, stall/flush=0 -> one edge later mem_wd=3, mem_wreg=1, mem_wdata=0x0000F0F0, mem_valid=1, cnt_o=0.
- madd sequence: cycle 1 stall_ex=1, stall_mem=0, ex_hilo_temp=0x00000001_00000002, ex_cnt=1 -> mem_valid=0, mem_wreg=0, hilo_temp_o=0x0000000100000002, cnt_o=1. Cycle 2 stall_ex=0, ex_whilo=1, ex_hi=0x1, ex_lo=0x5 -> mem_whilo=1, mem_lo=5, cnt_o=0, hilo_temp_o=0.
- Hold: load 0xDEADBEEF, then assert stall_ex=stall_mem=1 for 3 cycles while ex_wdata toggles -> mem_wdata stays 0xDEADBEEF and hilo_temp_o/cnt_o are unchanged.
- Flush priority: flush=1 together with stall_ex=stall_mem=1 while holding valid data -> all outputs read 0 the next cycle; with EX_MEM_PERF_EN, bubble_cnt increments by 1.
- Invalid qualifier: ex_valid=0, ex_wreg=1, ex_whilo=1, stall=0 -> mem_wreg=0, mem_whilo=0, mem_valid=0.
